// File: rtl/key_scan_pkg.sv
// Shared constants and event record for the keypad scanner.
package key_scan_pkg;

   localparam int KS_N_KEYS   = 12;
   localparam int KS_DIV      = 10;
   localparam int KS_DEBOUNCE = 3;

   // Wide enough for any practical keypad; the top truncates to its IDX_W.
   localparam int KS_CODE_W   = 8;

   typedef struct packed {
      logic                 valid;
      logic                 press;
      logic [KS_CODE_W-1:0] code;
   } key_event_t;

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: a two-state held FSM plus a run-length counter of
// disagreeing samples, advanced only when this key is the scanned one.
module key_debounce
   import key_scan_pkg::*;
#(
   parameter int DEBOUNCE = KS_DEBOUNCE
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic sample,
   output logic held,
   output logic toggle
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   typedef enum logic {
      KEY_UP   = 1'b0,
      KEY_DOWN = 1'b1
   } key_state_t;

   key_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_reg <= KEY_UP;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      toggle     = 1'b0;
      if (en) begin
         if (sample == held) begin
            // A bounce back to the settled level restarts the run.
            cnt_next = '0;
         end else if (cnt_reg == CNT_W'(DEBOUNCE - 1)) begin
            toggle     = 1'b1;
            cnt_next   = '0;
            state_next = (state_reg == KEY_UP) ? KEY_DOWN : KEY_UP;
         end else begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end
   end

   assign held = (state_reg == KEY_DOWN);

endmodule

// File: rtl/key_scanner.sv
// Keypad scanner: prescaled scan index, per-key debounce, one-cycle
// press/release events, and a raw registered select output for legacy users.
module key_scanner
   import key_scan_pkg::*;
#(
   parameter  int N_KEYS   = KS_N_KEYS,
   parameter  int DIV      = KS_DIV,
   parameter  int DEBOUNCE = KS_DEBOUNCE,
   localparam int IDX_W    = $clog2(N_KEYS)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SCAN_EN,
   input  logic              MODE,
   input  logic [N_KEYS-1:0] Din,
   output logic              Dout,
   output logic [IDX_W-1:0]  SCAN_IDX,
   output logic              KEY_VALID,
   output logic              KEY_PRESS,
   output logic [IDX_W-1:0]  KEY_CODE,
   output logic [N_KEYS-1:0] KEY_HELD
);

   localparam int PC_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PC_W-1:0]   pc_reg, pc_next;
   logic [IDX_W-1:0]  scan_idx_reg, scan_idx_next;
   logic              tick;
   logic              dout_reg;
   key_event_t        ev_reg, ev_next;
   logic [N_KEYS-1:0] key_en;
   logic [N_KEYS-1:0] key_held;
   logic [N_KEYS-1:0] key_toggle;
   logic              unused_code_bits;

   assign tick = SCAN_EN && (pc_reg == PC_W'(DIV - 1));

   always_comb begin
      pc_next       = pc_reg;
      scan_idx_next = scan_idx_reg;
      if (tick) begin
         pc_next       = '0;
         scan_idx_next = (scan_idx_reg == IDX_W'(N_KEYS - 1)) ? '0
                                                              : scan_idx_reg + IDX_W'(1);
      end else if (SCAN_EN) begin
         pc_next = pc_reg + PC_W'(1);
      end
   end

   // Only the scanned key can toggle, so the new level is simply its input.
   always_comb begin
      ev_next       = ev_reg;
      ev_next.valid = 1'b0;
      if (|key_toggle) begin
         ev_next.valid = MODE;
         ev_next.press = Din[scan_idx_reg];
         ev_next.code  = KS_CODE_W'(scan_idx_reg);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         pc_reg       <= '0;
         scan_idx_reg <= '0;
         ev_reg       <= '0;
         dout_reg     <= 1'b0;
      end else begin
         pc_reg       <= pc_next;
         scan_idx_reg <= scan_idx_next;
         ev_reg       <= ev_next;
         dout_reg     <= Din[scan_idx_reg];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         assign key_en[gi] = tick && (scan_idx_reg == IDX_W'(gi));

         key_debounce #(
            .DEBOUNCE (DEBOUNCE)
         ) u_debounce (
            .CLK    (CLK),
            .RST    (RST),
            .en     (key_en[gi]),
            .sample (Din[gi]),
            .held   (key_held[gi]),
            .toggle (key_toggle[gi])
         );
      end
   endgenerate

   assign unused_code_bits = ^ev_reg.code;

   assign Dout      = dout_reg;
   assign SCAN_IDX  = scan_idx_reg;
   assign KEY_VALID = ev_reg.valid;
   assign KEY_PRESS = ev_reg.press;
   assign KEY_CODE  = ev_reg.code[IDX_W-1:0];
   assign KEY_HELD  = key_held;

endmodule

// File: tb/tb_key_scanner.sv
// Bench for key_scanner: a default instance and a 4-key, DIV=1, DEBOUNCE=1
// instance share stimulus and are compared every cycle against a reference model.
module tb_key_scanner;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        scan_en = 1'b0;
   logic        mode    = 1'b0;
   logic [11:0] din     = '0;

   logic        dout_a, valid_a, press_a;
   logic [3:0]  idx_a, code_a;
   logic [11:0] held_a;

   logic        dout_b, valid_b, press_b;
   logic [1:0]  idx_b, code_b;
   logic [3:0]  held_b;

   int n_vec    = 0;
   int n_err    = 0;
   int ev_count = 0;

   // Reference state, one slot per instance.
   int   en_cnt [2];
   logic held_m [2][16];
   int   dis_m  [2][16];
   logic exp_dout [2];
   logic exp_valid[2];
   logic exp_press[2];
   int   exp_code [2];

   always #5 clk = ~clk;

   key_scanner #(.N_KEYS(12), .DIV(10), .DEBOUNCE(3)) u_dut_a (
      .CLK(clk), .RST(rst_n), .SCAN_EN(scan_en), .MODE(mode), .Din(din),
      .Dout(dout_a), .SCAN_IDX(idx_a), .KEY_VALID(valid_a), .KEY_PRESS(press_a),
      .KEY_CODE(code_a), .KEY_HELD(held_a)
   );

   key_scanner #(.N_KEYS(4), .DIV(1), .DEBOUNCE(1)) u_dut_b (
      .CLK(clk), .RST(rst_n), .SCAN_EN(scan_en), .MODE(mode), .Din(din[3:0]),
      .Dout(dout_b), .SCAN_IDX(idx_b), .KEY_VALID(valid_b), .KEY_PRESS(press_b),
      .KEY_CODE(code_b), .KEY_HELD(held_b)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Predicts the effect of the next clock edge from the inputs now applied.
   // The scan position is derived from the number of enabled cycles since reset.
   task automatic model_step(input int d, input int n, input int div, input int deb,
                             input logic [15:0] kin);
      int idx;
      if (!rst_n) begin
         en_cnt[d]    = 0;
         exp_dout[d]  = 1'b0;
         exp_valid[d] = 1'b0;
         exp_press[d] = 1'b0;
         exp_code[d]  = 0;
         for (int i = 0; i < 16; i++) begin
            held_m[d][i] = 1'b0;
            dis_m[d][i]  = 0;
         end
      end else begin
         idx          = (en_cnt[d] / div) % n;
         exp_dout[d]  = kin[idx];
         exp_valid[d] = 1'b0;
         if (scan_en) begin
            if (en_cnt[d] % div == div - 1) begin
               if (kin[idx] == held_m[d][idx]) begin
                  dis_m[d][idx] = 0;
               end else begin
                  dis_m[d][idx]++;
                  if (dis_m[d][idx] == deb) begin
                     held_m[d][idx] = kin[idx];
                     dis_m[d][idx]  = 0;
                     exp_valid[d]   = mode;
                     exp_press[d]   = kin[idx];
                     exp_code[d]    = idx;
                  end
               end
            end
            en_cnt[d]++;
         end
      end
   endtask

   function automatic logic [15:0] held_vec(input int d);
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = held_m[d][i];
      return v;
   endfunction

   task automatic cycle();
      model_step(0, 12, 10, 3, {4'b0, din});
      model_step(1, 4, 1, 1, {12'b0, din[3:0]});
      @(posedge clk);
      #1;
      if (valid_a) ev_count++;
      check_val("a_idx",   idx_a,   (en_cnt[0] / 10) % 12);
      check_val("a_dout",  dout_a,  exp_dout[0]);
      check_val("a_valid", valid_a, exp_valid[0]);
      check_val("a_press", press_a, exp_press[0]);
      check_val("a_code",  code_a,  exp_code[0]);
      check_val("a_held",  held_a,  held_vec(0));
      check_val("b_idx",   idx_b,   en_cnt[1] % 4);
      check_val("b_dout",  dout_b,  exp_dout[1]);
      check_val("b_valid", valid_b, exp_valid[1]);
      check_val("b_press", press_b, exp_press[1]);
      check_val("b_code",  code_b,  exp_code[1]);
      check_val("b_held",  held_b,  held_vec(1));
   endtask

   task automatic run(input int ncyc);
      for (int k = 0; k < ncyc; k++) cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int pat[6] = '{1, 0, 1, 1, 1, 1};

      // Reset state
      din = '0;
      run(3);
      check_val("rst_held", held_a, 12'h000);

      // Clean press and release of key 5
      scan_en = 1'b1;
      mode    = 1'b1;
      do_reset();
      din      = 12'h020;
      ev_count = 0;
      run(360);
      check_val("p5_events", ev_count, 1);
      check_val("p5_held",   held_a,   12'h020);
      din      = '0;
      ev_count = 0;
      run(360);
      check_val("r5_events", ev_count, 1);
      check_val("r5_press",  press_a,  0);

      // Bouncing key 2: one level change per scan round
      do_reset();
      ev_count = 0;
      for (int k = 0; k < 6; k++) begin
         din[2] = pat[k][0];
         run(120);
         if (k == 3) check_val("bounce_early", ev_count, 0);
      end
      check_val("bounce_evt", ev_count, 1);

      // Legacy mode: debounce runs, events suppressed
      mode = 1'b0;
      do_reset();
      din      = 12'h801;
      ev_count = 0;
      run(480);
      check_val("m0_events", ev_count, 0);
      check_val("m0_held",   held_a,   12'h801);
      check_val("m0_code",   code_a,   11);

      // Scan freeze mid-round
      mode = 1'b1;
      din  = 12'h0a4;
      run(55);
      scan_en = 1'b0;
      din     = 12'h35b;
      run(50);
      scan_en = 1'b1;
      run(400);

      // Reset with key 4 settled and key 0 part-way through debouncing
      do_reset();
      din = 12'h010;
      run(480);
      check_val("pre_held", held_a, 12'h010);
      din = 12'h011;
      run(130);
      rst_n = 1'b0;
      run(1);
      check_val("mid_rst_held", held_a, 12'h000);
      rst_n    = 1'b1;
      ev_count = 0;
      run(360);
      check_val("post_rst_events", ev_count, 2);
      check_val("post_rst_held",   held_a,   12'h011);

      // Randomised traffic
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(39) == 0) din[$urandom_range(11)] ^= 1'b1;
         scan_en = ($urandom_range(15) != 0);
         if ($urandom_range(199) == 0) mode = ~mode;
         rst_n = ($urandom_range(599) != 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
